// File: rtl/loop_test_ctrl_if.sv
// Link bundle between the loopback test controller and its data source / serial loop.
// The master side is the controller; the slave side is the source/transceiver environment.
interface loop_test_ctrl_if;
    logic        start;
    logic [7:0]  src_data;
    logic [7:0]  rx_data;
    logic        src_enable;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [3:0]  latency;
    logic [15:0] err_count;

    modport master (
        input  start, src_data, rx_data,
        output src_enable, tx_data, busy, done, pass, fail_code, latency, err_count
    );

    modport slave (
        output start, src_data, rx_data,
        input  src_enable, tx_data, busy, done, pass, fail_code, latency, err_count
    );
endinterface

// File: rtl/loop_test_ctrl.sv
// Loopback link tester: trains the link, measures round-trip latency with a marker word,
// then streams source bytes and counts received bytes that differ from the delayed transmit history.
module loop_test_ctrl #(
    parameter logic [7:0] TRAIN_PAT     = 8'hA5,
    parameter logic [7:0] MARKER        = 8'h3C,
    parameter int         LOCK_CNT      = 8,
    parameter int         TRAIN_TIMEOUT = 1024,
    parameter int         TEST_LEN      = 256
) (
    input logic              clk_50MHz,
    input logic              reset,
    loop_test_ctrl_if.master lnk
);

    typedef enum logic [2:0] {IDLE, TRAIN, MEASURE, RUN, DRAIN, DONE} state_t;

    localparam int CNT_MAX = (TRAIN_TIMEOUT > TEST_LEN + 16) ? TRAIN_TIMEOUT : TEST_LEN + 16;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   TRAIN_LAST = CNT_W'(TRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   RUN_LAST   = CNT_W'(TEST_LEN - 1);
    localparam logic [CNT_W-1:0]   MEAS_LAST  = CNT_W'(15);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [CNT_W-1:0]   lat_ext;
    logic [MATCH_W-1:0] match_cnt;
    logic [7:0]         tx_data, tx_nxt;
    logic [7:0]         hist [0:14];
    logic [7:0]         exp_byte;
    logic [3:0]         latency;
    logic [15:0]        err_count, err_nxt;
    logic [1:0]         fail_code;
    logic               pass;
    logic               busy;
    logic               cmp_en;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign busy    = (state != IDLE) && (state != DONE);
    assign lat_ext = CNT_W'(latency);

    // hist[k] holds tx_data from k+1 cycles ago, so latency 0 compares against the live word
    assign exp_byte = (latency == 4'd0) ? tx_data : hist[latency - 4'd1];
    assign cmp_en   = ((state == RUN) || (state == DRAIN)) && (cyc_cnt >= lat_ext);
    assign err_nxt  = (cmp_en && (lnk.rx_data != exp_byte)) ? sat_inc(err_count) : err_count;

    always_comb begin
        state_nxt = state;
        tx_nxt    = 8'h00;
        case (state)
            IDLE, DONE: if (lnk.start) state_nxt = TRAIN;
            TRAIN: begin
                if ((lnk.rx_data == TRAIN_PAT) && (match_cnt == MATCH_LAST)) state_nxt = MEASURE;
                else if (cyc_cnt == TRAIN_LAST)                             state_nxt = DONE;
            end
            MEASURE: begin
                if (lnk.rx_data == MARKER)     state_nxt = RUN;
                else if (cyc_cnt == MEAS_LAST) state_nxt = DONE;
            end
            RUN:   if (cyc_cnt == RUN_LAST) state_nxt = (latency == 4'd0) ? DONE : DRAIN;
            DRAIN: if (cyc_cnt == RUN_LAST + lat_ext) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase

        // tx_data is registered, so it is chosen by the state it will be presented in
        case (state_nxt)
            TRAIN, DRAIN: tx_nxt = TRAIN_PAT;
            MEASURE:      tx_nxt = (state != MEASURE) ? MARKER : TRAIN_PAT;
            RUN:          tx_nxt = lnk.src_data;
            default:      tx_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tx_data   <= 8'h00;
            cyc_cnt   <= '0;
            match_cnt <= '0;
            latency   <= 4'd0;
            err_count <= 16'd0;
            fail_code <= 2'd0;
            pass      <= 1'b0;
            for (int i = 0; i < 15; i++) hist[i] <= 8'h00;
        end else begin
            state   <= state_nxt;
            tx_data <= tx_nxt;
            hist[0] <= tx_data;
            for (int i = 1; i < 15; i++) hist[i] <= hist[i-1];

            // RUN and DRAIN share one count so the compare window spans both
            if ((state_nxt != state) && !((state == RUN) && (state_nxt == DRAIN)))
                cyc_cnt <= '0;
            else if (busy)
                cyc_cnt <= cyc_cnt + CNT_ONE;

            if ((state == TRAIN) && (lnk.rx_data == TRAIN_PAT))
                match_cnt <= match_cnt + MATCH_ONE;
            else
                match_cnt <= '0;

            if (((state == IDLE) || (state == DONE)) && (state_nxt == TRAIN)) begin
                err_count <= 16'd0;
                latency   <= 4'd0;
                fail_code <= 2'd0;
                pass      <= 1'b0;
            end else begin
                case (state)
                    TRAIN: if (state_nxt == DONE) begin
                        fail_code <= 2'd1;
                        pass      <= 1'b0;
                    end
                    MEASURE: begin
                        if (state_nxt == RUN) latency <= cyc_cnt[3:0];
                        else if (state_nxt == DONE) begin
                            latency   <= 4'd15;
                            fail_code <= 2'd2;
                            pass      <= 1'b0;
                        end
                    end
                    RUN, DRAIN: begin
                        err_count <= err_nxt;
                        if (state_nxt == DONE) begin
                            pass      <= (err_nxt == 16'd0);
                            fail_code <= 2'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign lnk.src_enable = (state == RUN);
    assign lnk.tx_data    = tx_data;
    assign lnk.busy       = busy;
    assign lnk.done       = (state == DONE);
    assign lnk.pass       = pass;
    assign lnk.fail_code  = fail_code;
    assign lnk.latency    = latency;
    assign lnk.err_count  = err_count;

endmodule

// File: tb/tb_loop_test_ctrl.sv
// Directed bench for loop_test_ctrl: a 3-cycle loopback model, a counting data source,
// and stuck-receiver scenarios, each checked against hand-derived results.
module tb_loop_test_ctrl;

    localparam int MODE_LOOP = 0;
    localparam int MODE_ZERO = 1;
    localparam int MODE_PAT  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;

    loop_test_ctrl_if lnk();

    loop_test_ctrl dut (
        .clk_50MHz (clk),
        .reset     (reset),
        .lnk       (lnk)
    );

    always #10 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   rx_mode = MODE_LOOP;
    bit   flip_on = 1'b0;
    int   src_cnt = 0;
    int   src_base = 0;
    logic [7:0] d1 = 8'h00, d2 = 8'h00, d3 = 8'h00;
    logic [7:0] rx_v;

    // Three-register loop: rx_data in a cycle equals tx_data from three cycles before
    always_ff @(posedge clk) begin
        d1 <= lnk.tx_data;
        d2 <= d1;
        d3 <= d2;
        if (lnk.src_enable) src_cnt <= src_cnt + 1;
    end

    function automatic bit flip_hit(input int k);
        return (k == 10) || (k == 50) || (k == 100) || (k == 200) || (k == 255);
    endfunction

    always_comb begin
        rx_v = d3;
        case (rx_mode)
            MODE_LOOP: if (flip_on && lnk.src_enable && flip_hit(src_cnt - src_base)) rx_v = d3 ^ 8'h01;
            MODE_ZERO: rx_v = 8'h00;
            MODE_PAT:  rx_v = 8'hA5;
            default:   rx_v = d3;
        endcase
    end

    assign lnk.rx_data  = rx_v;
    assign lnk.src_data = src_cnt[7:0];

    task automatic pulse_start();
        repeat (4) @(negedge clk);
        src_base  = src_cnt;
        lnk.start = 1'b1;
        @(negedge clk);
        lnk.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget) begin
            if (lnk.done) begin
                ok = 1'b1;
                break;
            end
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        lnk.start = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (lnk.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", lnk.busy); end
        checks++; if (lnk.done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", lnk.done); end
        checks++; if (lnk.tx_data !== 8'h00)   begin errors++; $display("FAIL reset_tx: got %h want 00", lnk.tx_data); end
        checks++; if (lnk.src_enable !== 1'b0) begin errors++; $display("FAIL reset_src_en: got %b want 0", lnk.src_enable); end
        checks++; if (lnk.err_count !== 16'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", lnk.err_count); end
        checks++; if (lnk.fail_code !== 2'd0 || lnk.pass !== 1'b0 || lnk.latency !== 4'd0) begin
            errors++; $display("FAIL reset_results: got fail=%0d pass=%b lat=%0d want 0 0 0", lnk.fail_code, lnk.pass, lnk.latency);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ideal(input string tag);
        int cyc;
        bit ok;
        rx_mode = MODE_LOOP;
        flip_on = 1'b0;
        pulse_start();
        checks++; if (lnk.busy !== 1'b1 || lnk.tx_data !== 8'hA5) begin
            errors++; $display("FAIL %s_train_entry: got busy=%b tx=%h want 1 a5", tag, lnk.busy, lnk.tx_data);
        end
        wait_done(2000, cyc, ok);
        checks++; if (!ok)               begin errors++; $display("FAIL %s_timeout: got no done want done within 2000", tag); end
        checks++; if (cyc != 274)        begin errors++; $display("FAIL %s_busy_cycles: got %0d want 274", tag, cyc); end
        checks++; if (lnk.latency !== 4'd3) begin errors++; $display("FAIL %s_latency: got %0d want 3", tag, lnk.latency); end
        checks++; if (lnk.err_count !== 16'd0) begin errors++; $display("FAIL %s_err: got %0d want 0", tag, lnk.err_count); end
        checks++; if (lnk.pass !== 1'b1 || lnk.fail_code !== 2'd0) begin
            errors++; $display("FAIL %s_verdict: got pass=%b fail=%0d want 1 0", tag, lnk.pass, lnk.fail_code);
        end
        checks++; if (src_cnt - src_base != 256) begin errors++; $display("FAIL %s_src_cycles: got %0d want 256", tag, src_cnt - src_base); end
        checks++; if (lnk.busy !== 1'b0 || lnk.tx_data !== 8'h00) begin
            errors++; $display("FAIL %s_done_outputs: got busy=%b tx=%h want 0 00", tag, lnk.busy, lnk.tx_data);
        end
    endtask

    task automatic test_errors();
        int cyc;
        bit ok;
        rx_mode = MODE_LOOP;
        flip_on = 1'b1;
        pulse_start();
        wait_done(2000, cyc, ok);
        flip_on = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL errors_timeout: got no done want done"); end
        checks++; if (lnk.err_count !== 16'd5) begin errors++; $display("FAIL errors_count: got %0d want 5", lnk.err_count); end
        checks++; if (lnk.pass !== 1'b0 || lnk.fail_code !== 2'd0 || lnk.latency !== 4'd3) begin
            errors++; $display("FAIL errors_verdict: got pass=%b fail=%0d lat=%0d want 0 0 3", lnk.pass, lnk.fail_code, lnk.latency);
        end
    endtask

    task automatic test_restart_clears();
        int cyc;
        bit ok;
        rx_mode = MODE_LOOP;
        pulse_start();
        checks++; if (lnk.err_count !== 16'd0 || lnk.latency !== 4'd0 || lnk.done !== 1'b0) begin
            errors++; $display("FAIL restart_clear: got err=%0d lat=%0d done=%b want 0 0 0", lnk.err_count, lnk.latency, lnk.done);
        end
        wait_done(2000, cyc, ok);
        checks++; if (!ok || lnk.pass !== 1'b1 || lnk.err_count !== 16'd0) begin
            errors++; $display("FAIL restart_rerun: got ok=%b pass=%b err=%0d want 1 1 0", ok, lnk.pass, lnk.err_count);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        int n;
        bit ok;
        rx_mode = MODE_LOOP;
        pulse_start();
        repeat (2) @(negedge clk);
        lnk.start = 1'b1;
        @(negedge clk);
        lnk.start = 1'b0;
        checks++; if (lnk.busy !== 1'b1 || lnk.tx_data !== 8'hA5) begin
            errors++; $display("FAIL ignore_train: got busy=%b tx=%h want 1 a5", lnk.busy, lnk.tx_data);
        end
        n = 0;
        while (!lnk.src_enable && n < 100) begin n++; @(negedge clk); end
        checks++; if (!lnk.src_enable) begin errors++; $display("FAIL ignore_run_entry: got src_enable=0 want 1 within 100"); end
        repeat (10) @(negedge clk);
        lnk.start = 1'b1;
        @(negedge clk);
        lnk.start = 1'b0;
        checks++; if (lnk.src_enable !== 1'b1 || lnk.busy !== 1'b1) begin
            errors++; $display("FAIL ignore_run: got src_en=%b busy=%b want 1 1", lnk.src_enable, lnk.busy);
        end
        wait_done(2000, cyc, ok);
        checks++; if (!ok || lnk.pass !== 1'b1 || src_cnt - src_base != 256) begin
            errors++; $display("FAIL ignore_result: got ok=%b pass=%b src=%0d want 1 1 256", ok, lnk.pass, src_cnt - src_base);
        end
    endtask

    task automatic test_train_timeout();
        int cyc;
        bit ok;
        rx_mode = MODE_ZERO;
        pulse_start();
        wait_done(3000, cyc, ok);
        checks++; if (!ok)        begin errors++; $display("FAIL train_to_done: got no done want done"); end
        checks++; if (cyc != 1024) begin errors++; $display("FAIL train_to_cycles: got %0d want 1024", cyc); end
        checks++; if (lnk.fail_code !== 2'd1 || lnk.pass !== 1'b0) begin
            errors++; $display("FAIL train_to_verdict: got fail=%0d pass=%b want 1 0", lnk.fail_code, lnk.pass);
        end
    endtask

    task automatic test_marker_timeout();
        int cyc;
        bit ok;
        rx_mode = MODE_PAT;
        pulse_start();
        wait_done(2000, cyc, ok);
        checks++; if (!ok || cyc != 24) begin errors++; $display("FAIL marker_to_cycles: got ok=%b cyc=%0d want 1 24", ok, cyc); end
        checks++; if (lnk.fail_code !== 2'd2 || lnk.pass !== 1'b0) begin
            errors++; $display("FAIL marker_to_verdict: got fail=%0d pass=%b want 2 0", lnk.fail_code, lnk.pass);
        end
        checks++; if (lnk.latency !== 4'd15) begin errors++; $display("FAIL marker_to_latency: got %0d want 15", lnk.latency); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        rx_mode = MODE_LOOP;
        pulse_start();
        n = 0;
        while (!lnk.src_enable && n < 100) begin n++; @(negedge clk); end
        repeat (20) @(negedge clk);
        checks++; if (lnk.src_enable !== 1'b1 || lnk.latency !== 4'd3) begin
            errors++; $display("FAIL midrun_pre: got src_en=%b lat=%0d want 1 3", lnk.src_enable, lnk.latency);
        end
        reset = 1'b0;
        #1;
        checks++; if (lnk.busy !== 1'b0 || lnk.src_enable !== 1'b0 || lnk.done !== 1'b0) begin
            errors++; $display("FAIL midrun_ctrl: got busy=%b src_en=%b done=%b want 0 0 0", lnk.busy, lnk.src_enable, lnk.done);
        end
        checks++; if (lnk.tx_data !== 8'h00 || lnk.latency !== 4'd0 || lnk.err_count !== 16'd0 || lnk.pass !== 1'b0 || lnk.fail_code !== 2'd0) begin
            errors++; $display("FAIL midrun_data: got tx=%h lat=%0d err=%0d pass=%b fail=%0d want 00 0 0 0 0",
                               lnk.tx_data, lnk.latency, lnk.err_count, lnk.pass, lnk.fail_code);
        end
        repeat (4) @(negedge clk);
        reset = 1'b1;
        test_ideal("after_reset");
    endtask

    initial begin
        lnk.start = 1'b0;
        test_reset();
        test_ideal("ideal");
        test_errors();
        test_restart_clears();
        test_start_ignored();
        test_train_timeout();
        test_marker_timeout();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/loop_test_ctrl.md
LOOP_TEST_CTRL -- requirements
Module: loop_test_ctrl

Interface
REQ-001 Parameter TRAIN_PAT, 8'hA5: training word driven during alignment.
REQ-002 Parameter MARKER, 8'h3C: latency-measurement word.
REQ-003 Parameter LOCK_CNT, 8: consecutive matching training words needed for lock.
REQ-004 Parameter TRAIN_TIMEOUT, 1024: max cycles in TRAIN before failure.
REQ-005 Parameter TEST_LEN, 256: number of source bytes sent in RUN.
REQ-006 Port clk_50MHz  in  1: sole clock, all logic rising-edge.
REQ-007 Port reset  in  1: asynchronous, active-low reset (0 = reset).
REQ-008 Port start  in  1: single-cycle test request.
REQ-009 Port src_data  in  8: byte from data source.
REQ-010 Port rx_data  in  8: recovered byte from receiver.
REQ-011 Port src_enable  out  1: advances data source when 1.
REQ-012 Port tx_data  out  8: registered byte to transmitter.
REQ-013 Port busy  out  1: 1 in any state except IDLE and DONE.
REQ-014 Port done  out  1: 1 while in DONE.
REQ-015 Port pass  out  1: test verdict, valid while done=1.
REQ-016 Port fail_code  out  2: 0 none, 1 train timeout, 2 marker timeout.
REQ-017 Port latency  out  4: measured loop latency in cycles.
REQ-018 Port err_count  out  16: mismatched bytes in RUN.

Function
REQ-019 FSM states SHALL be IDLE, TRAIN, MEASURE, RUN, DRAIN, DONE.
REQ-020 IDLE/DONE: start=1 -> TRAIN next cycle; err_count, latency, fail_code, pass clear on that transition.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 tx_data SHALL be 8'h00 in IDLE and DONE, TRAIN_PAT in TRAIN, src_data in RUN, TRAIN_PAT in DRAIN.
REQ-023 TRAIN: match counter increments when rx_data==TRAIN_PAT, clears to 0 on mismatch; reaching LOCK_CNT -> MEASURE.
REQ-024 TRAIN: TRAIN_TIMEOUT cycles without lock -> DONE with fail_code=1, pass=0; lock on the timeout cycle takes priority.
REQ-025 MEASURE: tx_data=MARKER for exactly the first cycle, then TRAIN_PAT; latency counter = 0 in marker cycle, +1 per cycle.
REQ-026 MEASURE: first cycle rx_data==MARKER -> latency captured as counter value, go to RUN.
REQ-027 MEASURE: counter reaching 15 without marker -> DONE, fail_code=2, pass=0, latency=15.
REQ-028 RUN: src_enable=1 for exactly TEST_LEN cycles, then DRAIN; src_enable=0 in all other states.
REQ-029 Controller SHALL keep 16-deep history of tx_data; expected byte = tx_data driven latency cycles earlier.
REQ-030 Comparison window SHALL start latency cycles after RUN entry and span exactly TEST_LEN cycles, extending through DRAIN.
REQ-031 Each compared cycle with rx_data != expected SHALL increment err_count, saturating at 16'hFFFF.
REQ-032 DRAIN SHALL last latency cycles (0 cycles when latency=0: direct to DONE), then DONE.
REQ-033 On entering DONE from DRAIN: pass=1 iff err_count==0 (including the final compared byte), fail_code=0.
REQ-034 DONE SHALL hold all results and done=1 until next start.

Reset
REQ-035 reset=0 SHALL immediately force state IDLE, tx_data=8'h00, src_enable=0, busy=0, done=0, pass=0, fail_code=0, latency=0, err_count=0, all counters and history to 0.
REQ-036 Reset mid-test SHALL abort without verdict; next start after reset release runs a full test.

Verification
REQ-037 Ideal loop, rx_data = tx_data delayed 3 cycles, TEST_LEN=256 -> latency=3, err_count=0, pass=1, src_enable high exactly 256 cycles.
REQ-038 Same loop, bit flips on 5 distinct compared bytes -> err_count=5, pass=0, fail_code=0.
REQ-039 rx_data stuck 8'h00 -> DONE after 1024 TRAIN cycles, fail_code=1, pass=0.
REQ-040 rx_data held at TRAIN_PAT, marker never returns -> fail_code=2, latency=15, pass=0.
REQ-041 reset=0 asserted mid-RUN -> all outputs at reset values same cycle; subsequent start with ideal loop -> pass=1.
REQ-042 start pulses during TRAIN and RUN ignored; start in DONE clears err_count and reruns test.
